// File: rtl/imem_program_loader.sv
// Encodes decoded RV32I instruction fields into 32-bit words and writes them to
// consecutive instruction-memory addresses, one word per two cycles.
module imem_program_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_LD  = 3'd2;
  localparam logic [2:0] FMT_S   = 3'd3;
  localparam logic [2:0] FMT_B   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_U   = 3'd6;
  localparam logic [2:0] FMT_RSV = 3'd7;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_U   = 7'b0110111;

  function automatic logic [31:0] encode(
    input logic [2:0]  fmt,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = 32'h0000_0000;
    case (fmt)
      FMT_R:   w = {f7, rs2, rs1, f3, rd, OP_R};
      FMT_I:   w = {imm[11:0], rs1, f3, rd, OP_I};
      FMT_LD:  w = {imm[11:0], rs1, f3, rd, OP_LD};
      FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
      FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_B};
      FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
      FMT_U:   w = {imm[31:12], rd, OP_U};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              bad_s;

  // Reserved format, odd branch/jump offset, or a full memory all abort the session.
  assign bad_s = (in_fmt == FMT_RSV) ||
                 (((in_fmt == FMT_B) || (in_fmt == FMT_J)) && in_imm[0]) ||
                 count_q[ADDR_W];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = '0;
    wdata_d = 32'h0000_0000;
    last_d  = last_q;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_LOAD: begin
        if (in_valid) begin
          if (bad_s) begin
            state_d = S_ERR;
          end else begin
            state_d = S_WRITE;
            wdata_d = encode(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
            addr_d  = ADDR_W'(BASE_ADDR) + count_q[ADDR_W-1:0];
            last_d  = in_last;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WRITE: begin
        count_d = count_q + (ADDR_W+1)'(1);
        state_d = last_q ? S_DONE : S_LOAD;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
    // A new session overrides whatever the current state decided.
    if (start) begin
      state_d = S_LOAD;
      count_d = '0;
      addr_d  = '0;
      wdata_d = 32'h0000_0000;
      last_d  = 1'b0;
    end else begin
      last_d  = last_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign imem_we    = (state_q == S_WRITE);
  assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: an 8-bit-address instance for the
// encoding, error and reset scenarios, and a 2-bit-address instance for capacity.
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, start2 = 1'b0;
  logic        in_valid8 = 1'b0, in_valid2 = 1'b0;
  logic [2:0]  in_fmt = 3'd0;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [6:0]  in_funct7 = 7'd0;
  logic [31:0] in_imm = 32'd0;
  logic        in_last = 1'b0;

  logic        ready8, we8, busy8, done8, err8;
  logic [7:0]  addr8;
  logic [31:0] wdata8;
  logic [8:0]  count8;
  logic        ready2, we2, busy2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  count2;

  logic        sel2 = 1'b0;
  logic        m_ready, m_we, m_busy, m_done, m_err;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [8:0]  m_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int hs_prev = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb_q[$];

  imem_program_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_valid(in_valid8), .in_ready(ready8),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we8), .imem_addr(addr8), .imem_wdata(wdata8),
    .busy(busy8), .done(done8), .err(err8), .count(count8)
  );

  imem_program_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(ready2),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
    .busy(busy2), .done(done2), .err(err2), .count(count2)
  );

  assign m_ready = sel2 ? ready2 : ready8;
  assign m_we    = sel2 ? we2    : we8;
  assign m_busy  = sel2 ? busy2  : busy8;
  assign m_done  = sel2 ? done2  : done8;
  assign m_err   = sel2 ? err2   : err8;
  assign m_addr  = sel2 ? {6'd0, addr2}  : addr8;
  assign m_wdata = sel2 ? wdata2 : wdata8;
  assign m_count = sel2 ? {6'd0, count2} : count8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference RV32I encoder built straight from the field layouts.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    case (f)
      3'd0: return {f7, rs2, rs1, f3, rd, 7'b0110011};
      3'd1: return {imm[11:0], rs1, f3, rd, 7'b0010011};
      3'd2: return {imm[11:0], rs1, f3, rd, 7'b0000011};
      3'd3: return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      3'd4: return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      3'd5: return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      3'd6: return {imm[31:12], rd, 7'b0110111};
      default: return 32'h0;
    endcase
  endfunction

  task automatic send(input logic [2:0] f, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input logic last, input logic want_err,
      input logic [31:0] exp_data, input logic [7:0] exp_addr, input logic hold,
      input string name);
    wr_t e;
    int n;
    in_fmt = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    if (!want_err) begin
      e.addr = exp_addr; e.data = exp_data;
      sb_q.push_back(e);
    end
    if (sel2) in_valid2 = 1'b1; else in_valid8 = 1'b1;
    n = 0;
    while (!m_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) begin
      checks++; failures++;
      $display("FAIL %s handshake_timeout in_ready=%b required 1", name, m_ready);
    end
    checks++;
    if (m_we !== 1'b0) begin
      failures++;
      $display("FAIL %s we_with_ready imem_we=%b required 0", name, m_we);
    end
    @(posedge clk);
    #1;
    hs_prev = hs_cyc;
    hs_cyc = cyc;
    if (!hold) begin
      in_valid8 = 1'b0; in_valid2 = 1'b0;
    end
    @(negedge clk);
    if (want_err) begin
      checks++;
      if (m_we !== 1'b0 || m_err !== 1'b1 || m_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s err_path we=%b err=%b ready=%b required 0/1/0", name, m_we, m_err, m_ready);
      end
    end else begin
      checks++;
      if (m_we !== 1'b1 || m_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s write_cycle we=%b ready=%b required 1/0", name, m_we, m_ready);
      end
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL %s scoreboard_empty size=0 required 1", name);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (m_addr !== e.addr) begin
          failures++;
          $display("FAIL %s addr got=%0d required %0d", name, m_addr, e.addr);
        end
        checks++;
        if (m_wdata !== e.data) begin
          failures++;
          $display("FAIL %s wdata got=%h required %h", name, m_wdata, e.data);
        end
      end
    end
  endtask

  task automatic do_start(input string name);
    @(negedge clk);
    if (sel2) start2 = 1'b1; else start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    checks++;
    if (m_ready !== 1'b1 || m_busy !== 1'b1 || m_err !== 1'b0 || m_count !== 9'd0) begin
      failures++;
      $display("FAIL %s start ready=%b busy=%b err=%b count=%0d required 1/1/0/0",
               name, m_ready, m_busy, m_err, m_count);
    end
  endtask

  task automatic check_done(input string name, input logic [8:0] exp_count);
    @(negedge clk);
    checks++;
    if (m_done !== 1'b1 || m_busy !== 1'b0 || m_count !== exp_count) begin
      failures++;
      $display("FAIL %s done done=%b busy=%b count=%0d required 1/0/%0d",
               name, m_done, m_busy, m_count, exp_count);
    end
    @(negedge clk);
    checks++;
    if (m_done !== 1'b0 || m_count !== exp_count) begin
      failures++;
      $display("FAIL %s done_pulse done=%b count=%0d required 0/%0d", name, m_done, m_count, exp_count);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({ready8, we8, busy8, done8, err8} !== 5'b0 || addr8 !== 8'd0 ||
        wdata8 !== 32'd0 || count8 !== 9'd0) begin
      failures++;
      $display("FAIL %s reset8 ready=%b we=%b busy=%b done=%b err=%b addr=%0d wdata=%h count=%0d required all 0",
               name, ready8, we8, busy8, done8, err8, addr8, wdata8, count8);
    end
    checks++;
    if ({ready2, we2, busy2, done2, err2} !== 5'b0 || addr2 !== 2'd0 ||
        wdata2 !== 32'd0 || count2 !== 3'd0) begin
      failures++;
      $display("FAIL %s reset2 ready=%b we=%b err=%b count=%0d required all 0",
               name, ready2, we2, err2, count2);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_program();
    sel2 = 1'b0;
    do_start("program");
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 1'b0, 32'h00500093, 8'd0, 1'b0, "prog_addi");
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 1'b0, 32'h002081B3, 8'd1, 1'b0, "prog_add");
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 1'b0, 32'h0020A423, 8'd2, 1'b0, "prog_sw");
    check_done("program", 9'd3);
  endtask

  task automatic test_encodings();
    sel2 = 1'b0;
    do_start("encodings");
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'hFE208EE3, 8'd0, 1'b0, "enc_beq");
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0, 1'b0, 32'h008000EF, 8'd1, 1'b0, "enc_jal");
    send(3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0, 1'b0, 32'h123452B7, 8'd2, 1'b0, "enc_lui");
    send(3'd2, 5'd9, 5'd4, 5'd0, 3'd2, 7'd0, 32'hFFFFF7F0,
         1'b0, 1'b0, model(3'd2, 5'd9, 5'd4, 5'd0, 3'd2, 7'd0, 32'hFFFFF7F0), 8'd3, 1'b0, "enc_lw");
    send(3'd0, 5'd7, 5'd6, 5'd5, 3'd0, 7'h20, 32'hDEADBEEF,
         1'b1, 1'b0, model(3'd0, 5'd7, 5'd6, 5'd5, 3'd0, 7'h20, 32'hDEADBEEF), 8'd4, 1'b0, "enc_sub");
    check_done("encodings", 9'd5);
  endtask

  task automatic test_errors();
    sel2 = 1'b0;
    do_start("err_b");
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0, 1'b1, 32'd0, 8'd0, 1'b0, "err_b_odd");
    in_valid8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ready8 !== 1'b0 || we8 !== 1'b0 || err8 !== 1'b1 || busy8 !== 1'b0) begin
        failures++;
        $display("FAIL err_hold ready=%b we=%b err=%b busy=%b required 0/0/1/0", ready8, we8, err8, busy8);
      end
    end
    in_valid8 = 1'b0;
    do_start("err_rsv");
    send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd4, 1'b0, 1'b1, 32'd0, 8'd0, 1'b0, "err_rsv");
    do_start("err_j");
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 1'b0, 1'b1, 32'd0, 8'd0, 1'b0, "err_j_odd");
    do_start("err_recover");
    send(3'd1, 5'd2, 5'd3, 5'd0, 3'd4, 7'd0, 32'h7FF,
         1'b1, 1'b0, model(3'd1, 5'd2, 5'd3, 5'd0, 3'd4, 7'd0, 32'h7FF), 8'd0, 1'b0, "err_recover");
    check_done("err_recover", 9'd1);
  endtask

  task automatic test_capacity();
    logic [31:0] imm;
    sel2 = 1'b1;
    do_start("capacity");
    for (int i = 0; i < 4; i++) begin
      imm = 32'(i * 4 + 1);
      send(3'd1, 5'(i + 1), 5'd2, 5'd0, 3'd0, 7'd0, imm, 1'b0, 1'b0,
           model(3'd1, 5'(i + 1), 5'd2, 5'd0, 3'd0, 7'd0, imm), 8'(i), 1'b0, "cap_write");
    end
    send(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 1'b1, 32'd0, 8'd0, 1'b0, "cap_overflow");
    checks++;
    if (m_count !== 9'd4) begin
      failures++;
      $display("FAIL cap_count got=%0d required 4", m_count);
    end
    sel2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    sel2 = 1'b0;
    do_start("reset_mid");
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 1'b0, 32'h00100093, 8'd0, 1'b0, "rm_w0");
    send(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 1'b0, 32'h00200113, 8'd1, 1'b0, "rm_w1");
    in_fmt = 3'd1; in_rd = 5'd3; in_imm = 32'd3; in_last = 1'b0;
    in_valid8 = 1'b1;
    n = 0;
    while (!ready8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    in_valid8 = 1'b0;
    checks++;
    if (we8 !== 1'b1 || addr8 !== 8'd2) begin
      failures++;
      $display("FAIL rm_write2 we=%b addr=%0d required 1/2", we8, addr8);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    do_start("reset_restart");
    send(3'd6, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 1'b1, 1'b0, 32'hABCDE237, 8'd0, 1'b0, "rm_restart");
    check_done("reset_restart", 9'd1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] imm;
    sel2 = 1'b0;
    do_start("b2b");
    for (int i = 0; i < 4; i++) begin
      imm = 32'(i * 8);
      send(3'd3, 5'd0, 5'(i), 5'(i + 10), 3'd2, 7'd0, imm, (i == 3), 1'b0,
           model(3'd3, 5'd0, 5'(i), 5'(i + 10), 3'd2, 7'd0, imm), 8'(i), (i != 3), "b2b");
      if (i > 0) begin
        checks++;
        if (hs_cyc - hs_prev != 2) begin
          failures++;
          $display("FAIL b2b_spacing got=%0d required 2", hs_cyc - hs_prev);
        end
      end
    end
    check_done("b2b", 9'd4);
  endtask

  initial begin
    test_reset();
    test_program();
    test_encodings();
    test_errors();
    test_capacity();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
